// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and its consumer.
interface alu_result_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_opcode;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  in_carryout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [3:0]            out_opcode;
  logic [3:0]            out_flags;

  modport master (
    output in_valid, in_opcode, in_result, in_carryout, out_ready,
    input  in_ready, out_valid, out_result, out_opcode, out_flags
  );

  modport slave (
    input  in_valid, in_opcode, in_result, in_carryout, out_ready,
    output in_ready, out_valid, out_result, out_opcode, out_flags
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Two-entry result FIFO behind the ALU: stores result, opcode and derived {I,N,Z,C}
// flags, and accumulates retired flags into a software-clearable sticky register.
module alu_result_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_buffer_if.slave  bus,
  input  logic                sticky_clr,
  output logic [3:0]          sticky_flags,
  output logic [1:0]          count
);

  logic [DATA_WIDTH-1:0] res_q [2];
  logic [DATA_WIDTH-1:0] res_d [2];
  logic [3:0]            op_q  [2];
  logic [3:0]            op_d  [2];
  logic [3:0]            flg_q [2];
  logic [3:0]            flg_d [2];
  logic                  rptr_q, rptr_d;
  logic                  wptr_q, wptr_d;
  logic [1:0]            count_q, count_d;
  logic [3:0]            sticky_q, sticky_d;

  logic       push, pop;
  logic [3:0] in_flags;

  assign bus.in_ready   = (count_q != 2'(DEPTH));
  assign bus.out_valid  = (count_q != 2'd0);
  assign bus.out_result = res_q[rptr_q];
  assign bus.out_opcode = op_q[rptr_q];
  assign bus.out_flags  = flg_q[rptr_q];
  assign sticky_flags   = sticky_q;
  assign count          = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // {I,N,Z,C}; carry is only meaningful for opcode 0000
  assign in_flags = {bus.in_opcode > 4'b1000,
                     bus.in_result[DATA_WIDTH-1],
                     bus.in_result == '0,
                     (bus.in_opcode == 4'b0000) && bus.in_carryout};

  always_comb begin
    res_d    = res_q;
    op_d     = op_q;
    flg_d    = flg_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (push) begin
      res_d[wptr_q] = bus.in_result;
      op_d[wptr_q]  = bus.in_opcode;
      flg_d[wptr_q] = in_flags;
      wptr_d        = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Clear wins over the old contents but not over the entry retiring this cycle
    if (sticky_clr) begin
      sticky_d = pop ? flg_q[rptr_q] : 4'b0000;
    end else if (pop) begin
      sticky_d = sticky_q | flg_q[rptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '{default: '0};
      op_q     <= '{default: '0};
      flg_q    <= '{default: '0};
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= 4'b0000;
    end else begin
      res_q    <= res_d;
      op_q     <= op_d;
      flg_q    <= flg_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_buffer;

  typedef struct {
    logic [7:0] res;
    logic [3:0] op;
    logic [3:0] fl;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sticky_clr = 1'b0;
  logic [3:0] sticky_flags;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  alu_result_buffer_if #(.DATA_WIDTH(8)) bus ();

  alu_result_buffer #(.DATA_WIDTH(8), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries and a sticky word.
  ent_t       mq[$];
  logic [3:0] m_sticky = 4'b0000;
  bit         started = 0;
  bit         rst_last = 0;

  always @(posedge clk) begin
    ent_t e;
    bit   do_push, do_pop;
    rst_last = rst;
    if (rst) begin
      mq.delete();
      m_sticky = 4'b0000;
      started = 1;
    end else begin
      do_push = bus.in_valid && (mq.size() < 2);
      do_pop  = bus.out_ready && (mq.size() > 0);
      if (sticky_clr) m_sticky = 4'b0000;
      if (do_pop) begin
        e = mq.pop_front();
        m_sticky = m_sticky | e.fl;
      end
      if (do_push) begin
        e.res = bus.in_result;
        e.op  = bus.in_opcode;
        e.fl  = {bus.in_opcode > 4'd8, bus.in_result[7], bus.in_result == 8'd0,
                 bus.in_opcode == 4'd0 && bus.in_carryout};
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("count", 32'(count), 32'(mq.size()));
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() != 2));
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      check("sticky", 32'(sticky_flags), 32'(m_sticky));
      if (mq.size() > 0) begin
        check("out_result", 32'(bus.out_result), 32'(mq[0].res));
        check("out_opcode", 32'(bus.out_opcode), 32'(mq[0].op));
        check("out_flags", 32'(bus.out_flags), 32'(mq[0].fl));
      end else if (rst_last) begin
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_opcode", 32'(bus.out_opcode), 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
      end
    end
  end

  // Apply one cycle of inputs; returns after the following falling edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] op,
                       input logic [7:0] res, input logic c, input logic ordy,
                       input logic clr);
    rst             = r;
    bus.in_valid    = v;
    bus.in_opcode   = op;
    bus.in_result   = res;
    bus.in_carryout = c;
    bus.out_ready   = ordy;
    sticky_clr      = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_opcode   = 4'd0;
    bus.in_result   = 8'd0;
    bus.in_carryout = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset and single op
    drive(1, 0, 4'd0, 8'd0, 0, 0, 0);
    drive(1, 0, 4'd0, 8'd0, 0, 0, 0);
    check("lit_rst_count", 32'(count), 32'd0);
    check("lit_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("lit_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("lit_rst_sticky", 32'(sticky_flags), 32'd0);
    drive(0, 1, 4'b0000, 8'h00, 1, 1, 0);
    check("lit_single_valid", 32'(bus.out_valid), 32'd1);
    check("lit_single_result", 32'(bus.out_result), 32'h00);
    check("lit_single_flags", 32'(bus.out_flags), 32'b0011);
    drive(0, 0, 4'd0, 8'd0, 0, 1, 0);
    check("lit_single_sticky", 32'(sticky_flags), 32'b0011);
    check("lit_single_count", 32'(count), 32'd0);

    // Fill and stall
    drive(0, 1, 4'b0001, 8'h05, 0, 0, 0);
    drive(0, 1, 4'b0100, 8'h80, 0, 0, 0);
    check("lit_full_count", 32'(count), 32'd2);
    check("lit_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(0, 1, 4'b0001, 8'h11, 0, 0, 0);
    check("lit_ignored_count", 32'(count), 32'd2);
    check("lit_head_result", 32'(bus.out_result), 32'h05);
    check("lit_head_flags", 32'(bus.out_flags), 32'b0000);
    drive(0, 0, 4'd0, 8'd0, 0, 1, 0);
    check("lit_second_result", 32'(bus.out_result), 32'h80);
    check("lit_second_flags", 32'(bus.out_flags), 32'b0100);
    check("lit_reready", 32'(bus.in_ready), 32'd1);
    drive(0, 0, 4'd0, 8'd0, 0, 1, 0);
    check("lit_drained", 32'(count), 32'd0);

    // Simultaneous push/pop at count 1, wrapping both pointers
    drive(0, 1, 4'b0010, 8'h20, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 4'b0010, 8'(8'h21 + i), 0, 1, 0);
      check("lit_stream_count", 32'(count), 32'd1);
      check("lit_stream_result", 32'(bus.out_result), 32'(8'h21 + i));
    end
    drive(0, 0, 4'd0, 8'd0, 0, 1, 0);

    // Carry masking and illegal opcode
    drive(0, 1, 4'b0001, 8'h01, 1, 0, 0);
    check("lit_carry_mask", 32'(bus.out_flags), 32'b0000);
    drive(0, 0, 4'd0, 8'd0, 0, 1, 0);
    drive(0, 1, 4'b1100, 8'h00, 0, 0, 0);
    check("lit_illegal_flags", 32'(bus.out_flags), 32'b1010);
    check("lit_illegal_result", 32'(bus.out_result), 32'h00);
    drive(0, 0, 4'd0, 8'd0, 0, 1, 0);

    // Sticky clear racing a pop
    drive(0, 0, 4'd0, 8'd0, 0, 0, 1);
    check("lit_clr_only_a", 32'(sticky_flags), 32'd0);
    drive(0, 1, 4'b1001, 8'h01, 0, 0, 0);
    drive(0, 1, 4'b0001, 8'h80, 0, 1, 0);
    check("lit_sticky_i", 32'(sticky_flags), 32'b1000);
    drive(0, 0, 4'd0, 8'd0, 0, 1, 1);
    check("lit_sticky_race", 32'(sticky_flags), 32'b0100);
    drive(0, 0, 4'd0, 8'd0, 0, 0, 1);
    check("lit_clr_only_b", 32'(sticky_flags), 32'd0);

    // Reset mid-operation, with a coinciding handshake that must be ignored
    drive(0, 1, 4'b0011, 8'h7f, 0, 0, 0);
    drive(0, 1, 4'b0000, 8'hff, 1, 1, 0);
    drive(0, 1, 4'b0101, 8'h42, 0, 0, 0);
    check("lit_mid_full", 32'(count), 32'd2);
    drive(1, 1, 4'b0101, 8'h42, 0, 1, 0);
    check("lit_mid_count", 32'(count), 32'd0);
    check("lit_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("lit_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("lit_mid_sticky", 32'(sticky_flags), 32'd0);
    check("lit_mid_result", 32'(bus.out_result), 32'd0);

    // Randomized traffic with occasional clear and reset
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0,
            1'($urandom_range(0, 3) != 0),
            4'($urandom),
            ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
            1'($urandom),
            1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage that sits directly downstream of the combinational `alu`. It captures each ALU result with its opcode and carry-out, and derives status flags. Results are held in a 2-entry FIFO behind a valid/ready handshake, so the ALU's consumer (writeback or register file) can stall without losing a result. It also keeps a sticky status register that accumulates the flags of every retired result until software clears it.

## Interface
- DATA_WIDTH, 8, width of result datapath; must match the upstream `alu`.
- DEPTH, 2, FIFO entries; fixed at 2, and other values are unsupported.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a result this cycle
- in_ready  output  1  buffer can accept (combinational from state)
- in_opcode  input  4  opcode that produced in_result
- in_result  input  DATA_WIDTH  ALU `result`
- in_carryout  input  1  ALU `carryout`
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer accepts head this cycle
- out_result  output  DATA_WIDTH  head result
- out_opcode  output  4  head opcode
- out_flags  output  4  head flags {I,N,Z,C}
- sticky_flags  output  4  OR of flags of all retired entries since last clear
- sticky_clr  input  1  clear sticky_flags
- count  output  2  entries held, 0..2

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != 2)`. It depends only on registered state and has no combinational path from out_ready.
- `out_valid = (count != 0)`. `out_result`, `out_opcode` and `out_flags` are driven from the head entry.
- Flags are computed at push and stored with the entry:
  - C = in_carryout when in_opcode == 4'b0000; otherwise 0.
  - N = in_result[DATA_WIDTH-1].
  - Z = (in_result == 0).
  - I = (in_opcode > 4'b1000), marking an illegal opcode. When I=1 the result is stored as received, with no forcing.
- Storage is two entry registers with a 1-bit read pointer and a 1-bit write pointer. Both pointers wrap modulo 2.
- count update rules:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop together: count unchanged. This is legal only when count==1, since count==2 blocks push and count==0 blocks pop.
- sticky_flags update rules:
  - sticky_clr && pop: sticky_flags ← flags of the popped entry. Clear takes effect first, then the retiring entry's flags are ORed in.
  - sticky_clr only: sticky_flags ← 0.
  - pop only: sticky_flags ← sticky_flags | out_flags.
  - Otherwise: hold.
- Data at the head must remain stable while `out_valid && !out_ready`.
- Inputs are ignored when `in_valid && !in_ready`. The upstream side must hold them.

## Timing
- Reset (rst=1 at clock edge) sets:
  - count=0, pointers=0, out_valid=0, in_ready=1, sticky_flags=0.
  - Entry storage cleared, so out_result=0, out_opcode=0, out_flags=0.
- Reset mid-operation discards all held entries. The cycle after reset shows count=0. Any handshake coinciding with the rst edge is ignored.
- Latency: a push at edge k makes out_valid=1 in the cycle after edge k, when the buffer was empty.
- Throughput: 1 result/cycle sustained when out_ready is held high.
- Back-pressure:
  - When count==2, in_ready deasserts in the cycle after the second push.
  - It reasserts in the cycle after the first pop.
- sticky_flags reflects a pop at edge k in the cycle after edge k.

## Test plan
- Reset and single op: rst for 2 cycles, then push opcode 0000 with result 8'h00 and carry 1, out_ready=1 → one cycle later out_valid=1, out_result=8'h00, out_flags=4'b0011. After the pop, sticky_flags=4'b0011 and count=0.
- Fill and stall: out_ready=0, then push 8'h05 (op 0001) and 8'h80 (op 0100) → count=2 and in_ready=0. A third push of 8'h11 is ignored. Release out_ready → pops 8'h05 (flags 0000) then 8'h80 (flags 0100), in order.
- Simultaneous push/pop at count=1 for 10 consecutive cycles with incrementing results → count stays 1 and outputs appear in order with no loss or duplication; pointer wrap is exercised.
- Carry masking: push op 0001 with in_carryout=1 and result 8'h01 → C=0, out_flags=4'b0000. Push op 1100 with result 8'h00 → out_flags=4'b1010 (I and Z).
- Sticky clear race: sticky_flags=4'b1000, then assert sticky_clr in the same cycle as popping an entry with flags 4'b0100 → next cycle sticky_flags=4'b0100. sticky_clr alone → 0.
- Reset mid-operation: with count=2 and out_valid=1, assert rst for one cycle → next cycle count=0, out_valid=0, in_ready=1, sticky_flags=0, out_result=0.
